// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Holds the FSM encoding, column reset pattern and key-code width.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam logic [3:0] COL_RESET = 4'b0001;
  localparam int KEY_W = 4;

  function automatic logic [3:0] col_rot(
    input logic [3:0] c
  );
    return {c[2:0], c[3]};
  endfunction

  // Lowest set row wins when several rows are high.
  function automatic logic [1:0] row_enc(
    input logic [3:0] f
  );
    logic [1:0] r;
    r = 2'd0;
    priority case (1'b1)
      f[0]: r = 2'd0;
      f[1]: r = 2'd1;
      f[2]: r = 2'd2;
      f[3]: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] col_enc(
    input logic [3:0] c
  );
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      c[0]: r = 2'd0;
      c[1]: r = 2'd1;
      c[2]: r = 2'd2;
      c[3]: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad matrix and key-code bundle between scanner and its neighbours.
// master = scanner side, slave = matrix/register-bank side.
interface keypad_if;
  import keypad_pkg::*;

  logic [3:0]       fila;
  logic [3:0]       col;
  logic [KEY_W-1:0] posicion;
  logic             opr;
  logic             pressed;

  modport master (
    input  fila,
    output col,
    output posicion,
    output opr,
    output pressed
  );

  modport slave (
    output fila,
    input  col,
    input  posicion,
    input  opr,
    input  pressed
  );

endinterface

// File: rtl/scan_tick_gen.sv
// Free-running clock divider for column stepping.
// tick is high for one clk while the count sits at DIV-1.
module scan_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot column drive, settle, key code + strobe.
// Define KEYPAD_REPEAT_EN to build auto-repeat of opr while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int SETTLE_CYC = 16
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 100
`endif
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  state_e           state_q, state_d;
  logic [3:0]       col_q, col_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0] pos_q, pos_d;
  logic             opr_q, opr_d;
  logic             pressed_q, pressed_d;
  logic             tick;
  logic             any_row;
  logic             rep_fire;

  assign any_row = |kp.fila;

  scan_tick_gen #(
    .DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      col_q     <= COL_RESET;
      cnt_q     <= '0;
      pos_q     <= '0;
      opr_q     <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      opr_q     <= opr_d;
      pressed_q <= pressed_d;
    end
  end

  // cnt_q counts held clks in SETTLE and released clks in HOLD.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SCAN: begin
        cnt_d = '0;
        if (tick) begin
          if (any_row) state_d = SETTLE;
          else         col_d   = col_rot(col_q);
        end
      end
      SETTLE: begin
        if (!any_row) begin
          state_d = SCAN;
          col_d   = col_rot(col_q);
          cnt_d   = '0;
        end else if (cnt_q == SW'(SETTLE_CYC - 1)) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        if (any_row) begin
          cnt_d = '0;
        end else if (cnt_q == SW'(SETTLE_CYC - 1)) begin
          state_d = SCAN;
          col_d   = col_rot(col_q);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SCAN;
        col_d   = COL_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pos_d     = pos_q;
    opr_d     = 1'b0;
    pressed_d = pressed_q;
    if (state_q == CAPTURE) begin
      pos_d     = {row_enc(kp.fila), col_enc(col_q)};
      opr_d     = 1'b1;
      pressed_d = 1'b1;
    end
    if (state_q == HOLD && state_d == SCAN) begin
      pressed_d = 1'b0;
    end
    if (rep_fire) begin
      opr_d = 1'b1;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY + 1);

  logic [RW-1:0] rep_q, rep_d;

  // After the first repeat, reload so the next fires REPEAT_PER ticks later.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_q != HOLD) begin
      rep_d = '0;
    end else if (tick) begin
      if (rep_q == RW'(REPEAT_DLY - 1)) begin
        rep_fire = 1'b1;
        rep_d    = RW'(REPEAT_DLY - REPEAT_PER);
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign kp.col      = col_q;
  assign kp.posicion = pos_q;
  assign kp.opr      = opr_q;
  assign kp.pressed  = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (CLK_DIV=4, SETTLE_CYC=3).
// Define KEYPAD_REPEAT_EN to also exercise the auto-repeat build.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_tot  = 0;
  logic [3:0] exp_q[$];
  logic opr_prev = 1'b0;

  keypad_if kp ();

  keypad_scanner #(
    .CLK_DIV    (4),
    .SETTLE_CYC (3)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DLY (4),
    .REPEAT_PER (2)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, got, exp);
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(logic [3:0] c, string nm);
    for (int i = 0; i < 64 && kp.col !== c; i++) @(negedge clk);
    chk(nm, kp.col, c);
  endtask

  task automatic wait_pressed(logic v, string nm);
    for (int i = 0; i < 64 && kp.pressed !== v; i++) @(negedge clk);
    chk(nm, kp.pressed, v);
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_col"}, kp.col, 4'b0001);
    chk({nm, "_pos"}, kp.posicion, 4'h0);
    chk({nm, "_opr"}, kp.opr, 1'b0);
    chk({nm, "_pressed"}, kp.pressed, 1'b0);
  endtask

  // Monitor: every strobe must match the oldest expected key code.
  always @(negedge clk) begin
    logic [3:0] e;
    if (kp.opr === 1'b1) begin
      chk("opr_gap", opr_prev, 1'b0);
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL opr_unexpected: got strobe with posicion %0h, required none",
                 kp.posicion);
      end else begin
        e = exp_q.pop_front();
        chk("posicion", kp.posicion, e);
        chk("pressed_at_opr", kp.pressed, 1'b1);
      end
    end
    opr_prev <= kp.opr;
  end

  initial begin
    logic [3:0] prev;
    rst     = 1'b1;
    kp.fila = 4'h0;
    cyc(2);
    chk_reset("reset");
    rst = 1'b0;

    // Idle scan: col steps every 4 clks and wraps.
    for (int k = 0; k < 20; k++) begin
      chk("idle_col", kp.col, 4'b0001 << ((k / 4) % 4));
      @(negedge clk);
    end

    // Press row 2 in column 2.
    wait_col(4'b0100, "press_sync");
    kp.fila = 4'b0100;
    exp_q.push_back(4'hA);
    wait_pressed(1'b1, "press_pressed");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("hold_col", kp.col, 4'b0100);
    end
    kp.fila = 4'h0;
    cyc(2);
    chk("release_early", kp.pressed, 1'b1);
    cyc(1);
    chk("release_pressed", kp.pressed, 1'b0);
    chk("release_col", kp.col, 4'b1000);

    // Glitch: row high on a tick and two more clks only.
    prev = kp.col;
    for (int i = 0; i < 16 && kp.col === prev; i++) @(negedge clk);
    chk("glitch_sync", kp.col, 4'b0001);
    cyc(3);
    kp.fila = 4'b0010;
    cyc(3);
    kp.fila = 4'h0;
    chk("glitch_frozen", kp.col, 4'b0001);
    cyc(1);
    chk("glitch_resume", kp.col, 4'b0010);
    chk("glitch_pressed", kp.pressed, 1'b0);

    // Multi-row at column 1: lowest row wins.
    wait_col(4'b0010, "multi_sync");
    kp.fila = 4'b0101;
    exp_q.push_back(4'h1);
    wait_pressed(1'b1, "multi_pressed");
    cyc(2);
    kp.fila = 4'h0;
    wait_pressed(1'b0, "multi_release");

    // Reset while holding row 0 in column 3.
    wait_col(4'b1000, "rst_sync");
    kp.fila = 4'b0001;
    exp_q.push_back(4'h3);
    wait_pressed(1'b1, "rst_pressed");
    cyc(2);
    rst     = 1'b1;
    kp.fila = 4'h0;
    cyc(1);
    chk_reset("midrst");
    rst = 1'b0;
    cyc(12);
    chk("postrst_pos", kp.posicion, 4'h0);
    chk("postrst_pressed", kp.pressed, 1'b0);

`ifdef KEYPAD_REPEAT_EN
    // Held key: capture strobe plus repeats at ticks 4, 6, 8, 10.
    wait_col(4'b0100, "rep_sync");
    kp.fila = 4'b1000;
    repeat (5) exp_q.push_back(4'hE);
    wait_pressed(1'b1, "rep_pressed");
    cyc(42);
    kp.fila = 4'h0;
    wait_pressed(1'b0, "rep_release");
    cyc(10);
    chk("rep_pos_kept", kp.posicion, 4'hE);
`endif

    cyc(4);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
